// File: rtl/ro_freq_counter_if.sv
// Result/handshake bundle between the oscillator frequency counter and
// its consumer (UART transmit path). The master requests measurements.
// The slave (the counter) reports busy/done and the latest result.
interface ro_freq_counter_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (
        output start,
        input  busy,
        input  done,
        input  count,
        input  overflow
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output count,
        output overflow
    );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter.
// Synchronizes the asynchronous oscillator into clk, detects rising edges
// and counts them over a window of GATE_CYCLES clocks. The result
// saturates at 2^COUNT_W-1 and flags overflow.
//
// A start request is latched for one cycle before the FSM leaves IDLE.
// The sequence is therefore: one armed cycle, two settle cycles,
// GATE_CYCLES count cycles, and one done cycle.
//
// Optional build macro RO_FREQ_CONT_EN: free-running back-to-back
// measurements after reset, with start ignored.
module ro_freq_counter #(
    parameter int GATE_CYCLES = 1024,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_in,
    ro_freq_counter_if.slave bus
);
    localparam int WIN_W = $clog2(GATE_CYCLES + 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(1);
    localparam logic [WIN_W-1:0] COUNT_LAST  = WIN_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;
    logic                   rise;
    logic                   start_pend;
    logic [WIN_W-1:0]       win_cnt;
    logic [COUNT_W-1:0]     acc;
    logic                   acc_ovf;
    logic [COUNT_W-1:0]     count_q;
    logic                   overflow_q;
    logic                   busy_c;
    logic                   done_c;

    // Increment that holds at full scale instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] a);
        return (a == {COUNT_W{1'b1}}) ? a : a + COUNT_W'(1);
    endfunction

    // True when one more edge would exceed the representable range.
    function automatic logic sat_hit(input logic [COUNT_W-1:0] a);
        return (a == {COUNT_W{1'b1}});
    endfunction

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ro_in};
            hist_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign rise = sync_p0[SYNC_STAGES-1] & ~hist_p1;

`ifdef RO_FREQ_CONT_EN
    logic start_unused;
    assign start_unused = bus.start;
    assign start_pend   = 1'b0;
`else
    // Arm on a start seen in IDLE; starts during a measurement are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend <= 1'b0;
        end else begin
            start_pend <= (state_q == ST_IDLE) && !start_pend && bus.start;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef RO_FREQ_CONT_EN
                state_d = ST_SETTLE;
`else
                busy_c = start_pend;
                if (start_pend) begin
                    state_d = ST_SETTLE;
                end
`endif
            end
            ST_SETTLE: begin
                busy_c = 1'b1;
                if (win_cnt == SETTLE_LAST) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                busy_c = 1'b1;
                if (win_cnt == COUNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
`ifdef RO_FREQ_CONT_EN
                state_d = ST_SETTLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window counter and edge accumulator; cleared whenever not measuring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    win_cnt <= (win_cnt == SETTLE_LAST) ? '0 : win_cnt + WIN_W'(1);
                end
                ST_COUNT: begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (rise) begin
                        acc <= sat_inc(acc);
                        if (sat_hit(acc)) begin
                            acc_ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                    win_cnt <= '0;
                    acc     <= '0;
                    acc_ovf <= 1'b0;
                end
            endcase
        end
    end

    // Result registers; updated only as the DONE cycle completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            count_q    <= acc;
            overflow_q <= acc_ovf;
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: two instances (16-bit and 4-bit result)
// share clock, reset and oscillator. Expected counts come from the recorded
// oscillator samples: rising transitions inside the measurement window,
// clipped to the result range.
module tb_ro_freq_counter;
    localparam int G    = 100;
    localparam int MAXC = 20000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ro_in = 1'b0;

    always #5 clk = ~clk;

    ro_freq_counter_if #(.COUNT_W(16)) ifa ();
    ro_freq_counter_if #(.COUNT_W(4))  ifb ();

    ro_freq_counter #(.GATE_CYCLES(G), .COUNT_W(16), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .bus(ifa)
    );
    ro_freq_counter #(.GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .bus(ifb)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc_n      = 0;
    logic samp [0:MAXC];
    int   mode       = 0;
    int   period     = 4;
    logic lvl        = 1'b0;
    logic [15:0] exp_last_a = '0;

    // Record the oscillator level seen at every clock edge.
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        if (cyc_n <= MAXC) samp[cyc_n] = ro_in;
    end

    // Oscillator stimulus, changed away from the sampling edge.
    always @(negedge clk) begin
        case (mode)
            0: ro_in = lvl;
            1: ro_in = ((cyc_n % period) < (period / 2));
            default: ro_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Rising transitions visible inside the window of a start sampled at edge k.
    function automatic int rises(input int k);
        int r = 0;
        for (int m = k + 2; m <= k + G + 1; m++) begin
            if (m <= MAXC && samp[m] === 1'b1 && samp[m-1] === 1'b0) r++;
        end
        return r;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? ifb.done : ifa.done;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic [15:0] get_count(input bit sel);
        return sel ? 16'(ifb.count) : ifa.count;
    endfunction

    function automatic logic get_ovf(input bit sel);
        return sel ? ifb.overflow : ifa.overflow;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) ifb.start = v;
        else     ifa.start = v;
    endtask

    task automatic wait_done(input bit sel, input int limit, output int e);
        e = -1;
        for (int i = 0; i < limit; i++) begin
            if (get_done(sel) === 1'b1) begin
                e = cyc_n;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the negedge right after done was seen; checks the result.
    task automatic check_result(input bit sel, input int k, input string tag);
        int r;
        logic [15:0] ec;
        logic        eo;
        r  = rises(k);
        if (sel) begin
            ec = (r > 15) ? 16'd15 : 16'(r);
            eo = (r > 15);
        end else begin
            ec = (r > 65535) ? 16'hFFFF : 16'(r);
            eo = (r > 65535);
            exp_last_a = ec;
        end
        vectors++;
        if (get_count(sel) !== ec) begin
            miscompares++;
            $display("FAIL %s_count: got %0d want %0d", tag, get_count(sel), ec);
        end
        vectors++;
        if (get_ovf(sel) !== eo) begin
            miscompares++;
            $display("FAIL %s_overflow: got %0b want %0b", tag, get_ovf(sel), eo);
        end
    endtask

    task automatic run_measure(input bit sel, input string tag);
        int k;
        int e;
        @(negedge clk);
        set_start(sel, 1'b1);
        k = cyc_n + 1;
        @(negedge clk);
        set_start(sel, 1'b0);
        wait_done(sel, G + 20, e);
        vectors++;
        if (e != k + G + 3) begin
            miscompares++;
            $display("FAIL %s_latency: done after edge %0d want %0d", tag, e, k + G + 3);
            return;
        end
        @(negedge clk);
        check_result(sel, k, tag);
        vectors++;
        if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_after: busy=%0b done=%0b want 0 0", tag,
                     get_busy(sel), get_done(sel));
        end
    endtask

    task automatic test_reset();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifa.busy, ifa.done, ifa.overflow} !== 3'b000 || ifa.count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_a: busy/done/ovf=%b count=%0d want 000 0",
                     {ifa.busy, ifa.done, ifa.overflow}, ifa.count);
        end
        vectors++;
        if ({ifb.busy, ifb.done, ifb.overflow} !== 3'b000 || ifb.count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_b: busy/done/ovf=%b count=%0d want 000 0",
                     {ifb.busy, ifb.done, ifb.overflow}, ifb.count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_square();
        mode = 1; period = 4;
        repeat (4) @(negedge clk);
        run_measure(0, "square");
        vectors++;
        if (exp_last_a !== 16'd25 || ifa.count !== 16'd25) begin
            miscompares++;
            $display("FAIL square_25: got %0d want 25", ifa.count);
        end
    endtask

    task automatic test_constant();
        mode = 0; lvl = 1'b0;
        repeat (4) @(negedge clk);
        run_measure(0, "const0");
        lvl = 1'b1;
        run_measure(0, "const1");
        vectors++;
        if (ifa.count !== 16'd0) begin
            miscompares++;
            $display("FAIL const1_zero: got %0d want 0", ifa.count);
        end
    endtask

    task automatic test_overflow();
        mode = 1; period = 4;
        repeat (4) @(negedge clk);
        run_measure(1, "sat");
        vectors++;
        if (ifb.count !== 4'd15 || ifb.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_fixed: got %0d/%0b want 15/1", ifb.count, ifb.overflow);
        end
        mode = 0; lvl = 1'b0;
        repeat (4) @(negedge clk);
        run_measure(1, "sat_clear");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                mode = 1;
                period = int'($urandom_range(3, 12));
            end else begin
                mode = 2;
            end
            repeat (int'($urandom_range(1, 7))) @(negedge clk);
            run_measure(1'(it % 2), "rand");
        end
    endtask

    task automatic test_ignore_start();
        int k;
        int t;
        int e = -1;
        int ndone = 0;
        logic [15:0] prev;
        mode = 1; period = 4;
        prev = exp_last_a;
        @(negedge clk);
        ifa.start = 1'b1;
        k = cyc_n + 1;
        for (int i = 0; i < G + 30; i++) begin
            @(negedge clk);
            t = cyc_n - k;
            ifa.start = (t == 5 || t == 50);
            if (ifa.done === 1'b1) begin
                ndone++;
                e = cyc_n;
                ifa.start = 1'b1;
            end
            if (t == 60) begin
                vectors++;
                if (ifa.count !== prev || ifa.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_count: count=%0d busy=%0b want %0d 1",
                             ifa.count, ifa.busy, prev);
                end
            end
            if (e >= 0 && cyc_n == e + 1) check_result(0, k, "ignore");
        end
        ifa.start = 1'b0;
        vectors++;
        if (ndone != 1 || e != k + G + 3) begin
            miscompares++;
            $display("FAIL ignore_done: dones=%0d at %0d want 1 at %0d", ndone, e, k + G + 3);
        end
        vectors++;
        if (ifa.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_cycle_start: busy=%0b want 0", ifa.busy);
        end
    endtask

    task automatic test_back_to_back();
        int k1;
        int e1;
        int e2;
        mode = 2;
        @(negedge clk);
        ifa.start = 1'b1;
        k1 = cyc_n + 1;
        @(negedge clk);
        wait_done(0, G + 20, e1);
        vectors++;
        if (e1 != k1 + G + 3) begin
            miscompares++;
            $display("FAIL b2b_first: done at %0d want %0d", e1, k1 + G + 3);
            ifa.start = 1'b0;
            return;
        end
        @(negedge clk);
        check_result(0, k1, "b2b1");
        wait_done(0, G + 20, e2);
        ifa.start = 1'b0;
        vectors++;
        if (e2 != e1 + 2 + G + 3) begin
            miscompares++;
            $display("FAIL b2b_second: done at %0d want %0d", e2, e1 + 2 + G + 3);
            return;
        end
        @(negedge clk);
        check_result(0, e1 + 2, "b2b2");
        repeat (3) @(negedge clk);
        vectors++;
        if (ifa.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stop: busy=%0b want 0", ifa.busy);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit bad = 1'b0;
        mode = 1; period = 4;
        run_measure(0, "pre_rst");
        @(negedge clk);
        ifa.start = 1'b1;
        k = cyc_n + 1;
        @(negedge clk);
        ifa.start = 1'b0;
        while (cyc_n < k + 42) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ifa.count !== 16'd0 || {ifa.busy, ifa.done, ifa.overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d busy/done/ovf=%b want 0 000",
                     ifa.count, {ifa.busy, ifa.done, ifa.overflow});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_last_a = '0;
        for (int i = 0; i < 2 * G; i++) begin
            @(negedge clk);
            if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL post_reset_idle: activity seen without start, want none");
        end
        run_measure(0, "post_rst");
    endtask

`ifdef RO_FREQ_CONT_EN
    task automatic test_continuous();
        int e;
        int e_prev = -1;
        bit bad = 1'b0;
        mode = 1; period = 4;
        for (int n = 0; n < 4; n++) begin
            wait_done(0, G + 10, e);
            vectors++;
            if (e < 0 || (e_prev >= 0 && e - e_prev != G + 3)) begin
                miscompares++;
                $display("FAIL cont_period: done at %0d prev %0d want spacing %0d", e, e_prev, G + 3);
                return;
            end
            vectors++;
            if (ifb.done !== 1'b1) begin
                miscompares++;
                $display("FAIL cont_done_b: got %0b want 1", ifb.done);
            end
            e_prev = e;
            @(negedge clk);
            check_result(0, e - G - 3, "cont_a");
            check_result(1, e - G - 3, "cont_b");
            if (ifa.busy !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad || ifa.count !== 16'd25) begin
            miscompares++;
            $display("FAIL cont_busy: busy dropped or count %0d want 25", ifa.count);
        end
    endtask
`endif

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        test_reset();
`ifdef RO_FREQ_CONT_EN
        test_continuous();
`else
        test_square();
        test_constant();
        test_overflow();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Measures the ring oscillator output `op` in the system clock domain. It counts rising edges of the oscillator signal over a fixed window of clock cycles.
- Result is a frequency word, count = f_ro * GATE_CYCLES / f_clk, handed to the UART transmit path.
- Oscillator input is fully asynchronous; the block synchronizes it and edge-detects it.
- Valid for f_ro < f_clk/2 after synchronization; faster oscillators must be prescaled upstream.

Parameters:
- GATE_CYCLES, 1024, measurement window length in clk cycles (>=1).
- COUNT_W, 16, width of the result counter.
- SYNC_STAGES, 2, synchronizer flops on ro_in (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ro_in  input  1  raw ring oscillator output, asynchronous to clk.
- start  input  1  request one measurement, sampled on clk rising edge.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse: count/overflow updated this cycle.
- count  output  COUNT_W  last completed measurement, held until the next done.
- overflow  output  1  last measurement saturated.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, count=0, overflow=0.
  - FSM in IDLE; window counter, edge accumulator and synchronizer flops cleared.
  - Reset mid-measurement discards the partial result.
- Synchronizer: SYNC_STAGES flops on ro_in, then one extra history flop. rise = sync_last & ~history.
- FSM:
  - IDLE: start=1 -> SETTLE. Clear accumulator and window counter; clear internal overflow flag.
  - SETTLE: lasts exactly 2 cycles. Rises in SETTLE are ignored, which flushes stale synchronizer history. -> COUNT.
  - COUNT: lasts exactly GATE_CYCLES cycles.
    - Each cycle with rise=1 increments the accumulator.
    - Accumulator at 2^COUNT_W-1 saturates (holds) and sets the overflow flag.
    - After the last COUNT cycle -> DONE.
  - DONE: 1 cycle.
    - done=1; count<=accumulator; overflow<=flag.
    - -> IDLE, or -> SETTLE under the optional feature.
- busy=1 in SETTLE, COUNT and DONE; busy=0 in IDLE.
- Latency: start sampled at edge k -> done=1 in the cycle beginning at edge k+GATE_CYCLES+3.
- Handshake boundaries:
  - start while busy=1: ignored, no queuing.
  - start in the same cycle as done: ignored (FSM is in DONE, not IDLE).
  - start held high continuously: a new measurement starts on each return to IDLE.
- count and overflow change only in DONE. They are stable at all other times, including while the next measurement runs.
- Window counter width: clog2(GATE_CYCLES+1); no wrap within a window.
- A rise in the final COUNT cycle is counted. A rise in DONE is not.

Optional Feature:
- Macro RO_FREQ_CONT_EN.
- Defined:
  - After reset the FSM enters SETTLE automatically and measures back-to-back: DONE -> SETTLE. start is ignored.
  - busy stays 1 permanently after reset release.
  - done pulses every GATE_CYCLES+3 cycles.
- Undefined: single-shot behaviour exactly as above.

Test Plan:
- GATE_CYCLES=100, ro_in square wave period 4 clk, start pulse -> done once, exactly 103 cycles after start sampled; count=25, overflow=0, busy low next cycle.
- ro_in held 0, then held 1 across a measurement -> count=0, overflow=0. Constant level produces no spurious edge, including the settle window.
- COUNT_W=4, GATE_CYCLES=100, ro_in period 4 -> count=15, overflow=1. Next run with ro_in constant -> count=0, overflow=0.
- start re-pulsed at cycles 5 and 50 after the first start -> both ignored; exactly one done. start asserted in the DONE cycle -> no new measurement.
- rst_n low at cycle 40 of COUNT with prior count=25 -> outputs 0 immediately (asynchronous). After release, busy=0 and no done until a new start.
- RO_FREQ_CONT_EN defined, GATE_CYCLES=100, ro_in period 4 -> done pulses every 103 cycles, count=25 each time, with no start asserted.
